aos_packet_loopback_mc: RTL



---
 rtl/aos_packet_loopback_mc.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/aos_packet_loopback_mc.sv
// aos_packet_loopback_mc: per-app loopback/staging buffer between the PCIS
// packet converters and the app slots. Each app owns a FWFT circular FIFO of
// {slot,data}; the read side drains only the FIFO picked by rd_app, so one
// stalled app never blocks another.
// Optional build macro AOS_LOOPBACK_STATS_EN adds per-app accepted-packet
// counters (stat_app/stat_count) and an overflow_sticky stall flag.

// One app channel: storage, pointers and occupancy count.
module aos_lb_chan #(
  parameter int ENTRY_W   = 528,
  parameter int LOG_DEPTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr,
  input  logic                 rd,
  input  logic                 clr,
  input  logic [ENTRY_W-1:0]   wr_entry,
  output logic [ENTRY_W-1:0]   head,
  output logic [LOG_DEPTH:0]   count,
  output logic                 full,
  output logic                 empty
`ifdef AOS_LOOPBACK_STATS_EN
  ,
  output logic [31:0]          stat
`endif
);
  logic [ENTRY_W-1:0]   mem [2**LOG_DEPTH];
  logic [LOG_DEPTH-1:0] wptr, rptr;

  // Count never exceeds 2^LOG_DEPTH, so its top bit alone marks full.
  assign full  = count[LOG_DEPTH];
  assign empty = (count == '0);
  assign head  = mem[rptr];

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= wr_entry;
  end

  // Pointer/count update; flush wins, and the top never issues wr/rd with clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef AOS_LOOPBACK_STATS_EN
  // Saturating accepted-packet counter, cleared by reset or flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     stat <= '0;
    else if (clr)                stat <= '0;
    else if (wr && stat != '1)   stat <= stat + 1'b1;
  end
`endif
endmodule

module aos_packet_loopback_mc #(
  parameter int NUM_APPS   = 4,
  parameter int APP_BITS   = 2,
  parameter int DATA_WIDTH = 512,
  parameter int SLOT_WIDTH = 16,
  parameter int LOG_DEPTH  = 6
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [APP_BITS-1:0]               in_app,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic [SLOT_WIDTH-1:0]             in_slot,
  input  logic [APP_BITS-1:0]               rd_app,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic [SLOT_WIDTH-1:0]             out_slot,
  input  logic                              flush,
  input  logic [APP_BITS-1:0]               flush_app,
  output logic [NUM_APPS*(LOG_DEPTH+1)-1:0] level
`ifdef AOS_LOOPBACK_STATS_EN
  ,
  input  logic [APP_BITS-1:0]               stat_app,
  output logic [31:0]                       stat_count,
  output logic                              overflow_sticky
`endif
);
  localparam int ENTRY_W = SLOT_WIDTH + DATA_WIDTH;

  logic [NUM_APPS-1:0]                wr_vec, rd_vec, clr_vec, full_vec, empty_vec;
  logic [NUM_APPS-1:0][ENTRY_W-1:0]   heads;
  logic [NUM_APPS-1:0][LOG_DEPTH:0]   cnt;
  logic [ENTRY_W-1:0]                 head_sel;
`ifdef AOS_LOOPBACK_STATS_EN
  logic [NUM_APPS-1:0][31:0]          stats;
  logic                               stall_q;
`endif

  // Handshake qualifiers: a flushing app neither accepts nor presents data.
  always_comb begin
    in_ready  = !rst && !full_vec[in_app] && !(flush && flush_app == in_app);
    out_valid = !rst && !empty_vec[rd_app] && !(flush && flush_app == rd_app);
    head_sel  = heads[rd_app];
    out_data  = head_sel[DATA_WIDTH-1:0];
    out_slot  = head_sel[ENTRY_W-1 -: SLOT_WIDTH];
  end

  // Packed count array flattens to app k at k*(LOG_DEPTH+1).
  assign level = cnt;

  for (genvar k = 0; k < NUM_APPS; k++) begin : g_chan
    assign wr_vec[k]  = in_valid && in_ready && (in_app == APP_BITS'(k));
    assign rd_vec[k]  = out_valid && out_ready && (rd_app == APP_BITS'(k));
    assign clr_vec[k] = flush && (flush_app == APP_BITS'(k));

    aos_lb_chan #(
      .ENTRY_W   (ENTRY_W),
      .LOG_DEPTH (LOG_DEPTH)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .wr       (wr_vec[k]),
      .rd       (rd_vec[k]),
      .clr      (clr_vec[k]),
      .wr_entry ({in_slot, in_data}),
      .head     (heads[k]),
      .count    (cnt[k]),
      .full     (full_vec[k]),
      .empty    (empty_vec[k])
`ifdef AOS_LOOPBACK_STATS_EN
      ,
      .stat     (stats[k])
`endif
    );
  end

`ifdef AOS_LOOPBACK_STATS_EN
  assign stat_count = stats[stat_app];

  // Sticky flag: a refused write held for two consecutive cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q         <= 1'b0;
      overflow_sticky <= 1'b0;
    end else begin
      stall_q <= in_valid && !in_ready;
      if (in_valid && !in_ready && stall_q) overflow_sticky <= 1'b1;
    end
  end
`endif
endmodule
